interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width (>=16).
REQ-002 SHALL have parameter STACK_PAGE, default 8'h01, stack page high byte.
REQ-003 SHALL have parameters VEC_NMI / VEC_RES / VEC_IRQ, defaults 16'hFFFA / 16'hFFFC / 16'hFFFE, vector-low addresses, zero-extended to ADDR_W.
REQ-004 SHALL have parameter NMI_EDGE, default 1: 1 = rising-edge NMI, 0 = level NMI.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 ready  in  1  1 = advance; 0 = freeze state and all outputs.
REQ-008 irq  in  1  level interrupt request; nmi  in  1  non-maskable request; brk  in  1  one-cycle pulse on decoded opcode 8'h00.
REQ-009 iflag  in  1  I flag; sp  in  8  stack pointer; pc  in  ADDR_W  return address; pstat  in  8  status byte; din  in  8  read data.
REQ-010 addr  out  ADDR_W; dout  out  8; rw  out  1 (1 = write); spdec  out  1; setidis  out  1; busy  out  1; kind  out  2 (0 reset, 1 nmi, 2 irq, 3 brk); pcload  out  1; pcnew  out  ADDR_W.

Function
REQ-011 States SHALL be IDLE, DUMMY, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, LOAD, one state per clk with ready=1, in that order, LOAD returning to IDLE.
REQ-012 In IDLE, start priority SHALL be reset pending > nmi pending > brk > (irq & !iflag); start latches kind and enters DUMMY next edge; none pending stays IDLE.
REQ-013 busy SHALL be 1 in every state except IDLE.
REQ-014 DUMMY: addr = pc, rw = 0.
REQ-015 PUSH_H/PUSH_L/PUSH_P: addr = {STACK_PAGE, sp} zero-extended, spdec = 1; dout = pc[15:8], pc[7:0], pstat respectively with dout bit5 = 1 and bit4 = 1 only when kind = brk.
REQ-016 Push states SHALL have rw = 1, except kind = reset, where rw = 0 (dummy read) while spdec still pulses.
REQ-017 VEC_L: addr = vector(kind), rw = 0, setidis = 1, din captured as low byte; VEC_H: addr = vector+1, din captured as high byte.
REQ-018 LOAD: pcload = 1 for exactly one cycle, pcnew = {zero-ext, high, low}; pcnew holds value until next LOAD.
REQ-019 NMI_EDGE=1: nmi pending SHALL set on 0->1 of nmi sampled at clk in any state; held level SHALL NOT re-trigger.
REQ-020 NMI hijack: if nmi pending is set before VEC_L of an irq or brk sequence, kind SHALL become nmi and VEC_NMI be fetched; pushed status keeps original B bit.
REQ-021 nmi pending SHALL clear on entering VEC_L of an nmi sequence; an edge arriving in the same cycle SHALL remain pending.
REQ-022 irq/brk SHALL be ignored while busy; brk is not latched.
REQ-023 ready = 0 SHALL hold state, captured bytes, and combinational outputs unchanged; nmi edge detection continues.
REQ-024 sp and pc SHALL be used as presented each cycle; block does not store sp.

Reset
REQ-025 clr = 1 SHALL asynchronously force IDLE, kind = 0, pcload = 0, pcnew = 0, nmi pending = 0, nmi history = 0, captured bytes = 0, and set reset pending = 1.
REQ-026 During clr all outputs SHALL be 0 (addr = 0, rw = 0, spdec = 0, setidis = 0, busy = 0).
REQ-027 clr asserted mid-sequence SHALL abort; after release, a fresh reset sequence SHALL start from DUMMY on the first edge.
REQ-028 reset pending SHALL clear on entering DUMMY.

Verification
REQ-029 Release clr, din = 8'h34 at FFFC, 8'h12 at FFFD -> 3 spdec pulses with rw = 0, pcload at edge 7, pcnew = 16'h1234, kind = 0.
REQ-030 IDLE, iflag = 0, irq = 1, sp = 8'hFD, pc = 16'hC005, pstat = 8'h00 -> writes C0 @01FD, 05 @01FD, 8'h20 @01FD (sp static), vector FFFE, setidis in VEC_L.
REQ-031 brk pulse, pstat = 8'h01 -> PUSH_P dout = 8'h31, kind = 3; irq = 1 with iflag = 1 alone -> stays IDLE.
REQ-032 brk sequence, nmi rises during PUSH_L -> VEC_L addr = FFFA, kind = 1, pushed status 8'h30; held nmi causes no second sequence.
REQ-033 ready = 0 for 3 cycles in VEC_L -> addr/state frozen, total latency +3; clr during PUSH_P -> immediate IDLE, reset sequence follows release.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - reset/nmi/irq/brk entry sequencer: dummy read, three pushes, vector fetch, pc load
module interrupt_sequencer #(
  parameter int          ADDR_W     = 16,
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] VEC_NMI    = 16'hFFFA,
  parameter logic [15:0] VEC_RES    = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ    = 16'hFFFE,
  parameter bit          NMI_EDGE   = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ready,
  input  logic              irq,
  input  logic              nmi,
  input  logic              brk,
  input  logic              iflag,
  input  logic [7:0]        sp,
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        pstat,
  input  logic [7:0]        din,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        dout,
  output logic              rw,
  output logic              spdec,
  output logic              setidis,
  output logic              busy,
  output logic [1:0]        kind,
  output logic              pcload,
  output logic [ADDR_W-1:0] pcnew
);

  typedef enum logic [2:0] {
    IDLE, DUMMY, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, LOAD
  } state_t;

  localparam logic [1:0] K_RES = 2'd0;
  localparam logic [1:0] K_NMI = 2'd1;
  localparam logic [1:0] K_IRQ = 2'd2;
  localparam logic [1:0] K_BRK = 2'd3;

  state_t            state;
  logic              res_pend;
  logic              nmi_pend;
  logic              nmi_prev;
  logic [7:0]        lo_byte;
  logic [7:0]        hi_byte;
  logic              nmi_set;
  logic              nmi_vec_entry;
  logic [ADDR_W-1:0] vec;

  assign nmi_set = NMI_EDGE ? (nmi & ~nmi_prev) : nmi;

  // An irq/brk sequence with nmi pending at the vector fetch is taken over by nmi.
  assign nmi_vec_entry = ready && (state == PUSH_P) &&
                         ((kind == K_NMI) || (nmi_pend && (kind == K_IRQ || kind == K_BRK)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      kind     <= K_RES;
      res_pend <= 1'b1;
      nmi_pend <= 1'b0;
      nmi_prev <= 1'b0;
      lo_byte  <= 8'h00;
      hi_byte  <= 8'h00;
      pcnew    <= '0;
    end else begin
      nmi_prev <= nmi;
      // A new edge wins over the clear so it is not lost.
      if (nmi_set)
        nmi_pend <= 1'b1;
      else if (nmi_vec_entry)
        nmi_pend <= 1'b0;
      if (ready) begin
        case (state)
          IDLE: begin
            if (res_pend) begin
              res_pend <= 1'b0;
              kind     <= K_RES;
              state    <= DUMMY;
            end else if (nmi_pend) begin
              kind  <= K_NMI;
              state <= DUMMY;
            end else if (brk) begin
              kind  <= K_BRK;
              state <= DUMMY;
            end else if (irq && !iflag) begin
              kind  <= K_IRQ;
              state <= DUMMY;
            end
          end
          DUMMY:  state <= PUSH_H;
          PUSH_H: state <= PUSH_L;
          PUSH_L: state <= PUSH_P;
          PUSH_P: begin
            if (nmi_vec_entry)
              kind <= K_NMI;
            state <= VEC_L;
          end
          VEC_L: begin
            lo_byte <= din;
            state   <= VEC_H;
          end
          VEC_H: begin
            hi_byte <= din;
            pcnew   <= ADDR_W'({din, lo_byte});
            state   <= LOAD;
          end
          LOAD:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (kind)
      K_RES:   vec = ADDR_W'(VEC_RES);
      K_NMI:   vec = ADDR_W'(VEC_NMI);
      default: vec = ADDR_W'(VEC_IRQ);
    endcase
  end

  always_comb begin
    addr    = '0;
    dout    = 8'h00;
    rw      = 1'b0;
    spdec   = 1'b0;
    setidis = 1'b0;
    busy    = (state != IDLE);
    pcload  = (state == LOAD);
    case (state)
      DUMMY: addr = pc;
      PUSH_H, PUSH_L, PUSH_P: begin
        addr  = ADDR_W'({STACK_PAGE, sp});
        spdec = 1'b1;
        // Reset walks the stack with reads so memory is left untouched.
        rw    = (kind != K_RES);
        if (state == PUSH_H)
          dout = pc[15:8];
        else if (state == PUSH_L)
          dout = pc[7:0];
        else
          dout = {pstat[7:6], 1'b1, (kind == K_BRK), pstat[3:0]};
      end
      VEC_L: begin
        addr    = vec;
        setidis = 1'b1;
      end
      VEC_H:   addr = vec + ADDR_W'(1);
      default: addr = '0;
    endcase
  end

  logic unused_hi;
  assign unused_hi = ^hi_byte;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        clr, ready, irq, nmi, brk, iflag;
  logic [7:0]  sp, pstat, din, dout;
  logic [15:0] pc, addr, pcnew;
  logic        rw, spdec, setidis, busy, pcload;
  logic [1:0]  kind;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        rw;
    logic        spdec;
    logic        setidis;
    logic        pcload;
    logic [1:0]  kind;
    logic [15:0] pcnew;
  } exp_t;

  exp_t exp_q[$];

  interrupt_sequencer dut (
    .clk(clk), .clr(clr), .ready(ready), .irq(irq), .nmi(nmi), .brk(brk),
    .iflag(iflag), .sp(sp), .pc(pc), .pstat(pstat), .din(din),
    .addr(addr), .dout(dout), .rw(rw), .spdec(spdec), .setidis(setidis),
    .busy(busy), .kind(kind), .pcload(pcload), .pcnew(pcnew)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'hBC;
      16'hFFFB: return 8'h9A;
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'hFFFE: return 8'h78;
      16'hFFFF: return 8'h56;
      default:  return 8'hEA;
    endcase
  endfunction

  always_comb din = rd(addr);

  function automatic logic [15:0] vec_of(input logic [1:0] k);
    case (k)
      2'd0:    return 16'hFFFC;
      2'd1:    return 16'hFFFA;
      default: return 16'hFFFE;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // k0 is the starting kind, k1 the kind seen from the vector fetch on.
  task automatic push_seq(input logic [1:0] k0, input logic [1:0] k1, input logic [7:0] spv,
                          input logic [15:0] pcv, input logic [7:0] ps, input int n);
    exp_t e[7];
    logic [15:0] v;
    v = vec_of(k1);
    for (int i = 0; i < 7; i++) e[i] = '0;
    e[0].addr = pcv;                e[0].kind = k0;
    for (int i = 1; i <= 3; i++) begin
      e[i].addr = {8'h01, spv}; e[i].rw = (k0 != 2'd0); e[i].spdec = 1'b1; e[i].kind = k0;
    end
    e[1].dout = pcv[15:8];
    e[2].dout = pcv[7:0];
    e[3].dout = {ps[7:6], 1'b1, (k0 == 2'd3), ps[3:0]};
    e[4].addr = v;        e[4].setidis = 1'b1; e[4].kind = k1;
    e[5].addr = v + 16'd1; e[5].kind = k1;
    e[6].pcload = 1'b1;   e[6].kind = k1; e[6].pcnew = {rd(v + 16'd1), rd(v)};
    for (int i = 0; i < n; i++) exp_q.push_back(e[i]);
  endtask

  always @(negedge clk) begin
    if (!clr && busy && ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_busy", 32'(busy), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (!e.pcload) check("addr", 32'(addr), 32'(e.addr));
        check("rw", 32'(rw), 32'(e.rw));
        check("spdec", 32'(spdec), 32'(e.spdec));
        check("setidis", 32'(setidis), 32'(e.setidis));
        check("kind", 32'(kind), 32'(e.kind));
        check("pcload", 32'(pcload), 32'(e.pcload));
        if (e.rw) check("dout", 32'(dout), 32'(e.dout));
        if (e.pcload) check("pcnew", 32'(pcnew), 32'(e.pcnew));
      end
    end
  end

  task automatic run_seq(input int stall_at, input int nmi_at, input logic [15:0] stall_addr,
                         output int lat);
    bit done;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      irq = 1'b0;
      brk = 1'b0;
      if (lat == nmi_at) nmi = 1'b1;
      if (lat == stall_at) begin
        ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          lat++;
          check("stall_addr", 32'(addr), 32'(stall_addr));
          check("stall_setidis", 32'(setidis), 32'd1);
        end
        ready = 1'b1;
      end
      if (pcload) done = 1'b1;
    end
    if (!done) check("seq_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    clr = 1'b1; ready = 1'b1; irq = 1'b0; nmi = 1'b0; brk = 1'b0; iflag = 1'b1;
    sp = 8'hFD; pc = 16'hC005; pstat = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_spdec", 32'(spdec), 32'd0);
    check("rst_setidis", 32'(setidis), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pcload", 32'(pcload), 32'd0);
    check("rst_pcnew", 32'(pcnew), 32'd0);
    check("rst_kind", 32'(kind), 32'd0);

    push_seq(2'd0, 2'd0, 8'hFD, 16'hC005, 8'h00, 7);
    clr = 1'b0;
    run_seq(0, 0, 16'h0, lat);
    check("reset_latency", 32'(lat), 32'd7);
    check("reset_pcnew", 32'(pcnew), 32'h1234);
    check("reset_kind", 32'(kind), 32'd0);

    iflag = 1'b0; irq = 1'b1;
    push_seq(2'd2, 2'd2, 8'hFD, 16'hC005, 8'h00, 7);
    run_seq(0, 0, 16'h0, lat);
    iflag = 1'b1;
    check("irq_latency", 32'(lat), 32'd7);
    check("irq_pcnew", 32'(pcnew), 32'h5678);

    sp = 8'hF0; pc = 16'h8000; pstat = 8'h01; brk = 1'b1;
    push_seq(2'd3, 2'd3, 8'hF0, 16'h8000, 8'h01, 7);
    run_seq(0, 0, 16'h0, lat);
    check("brk_latency", 32'(lat), 32'd7);

    irq = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("masked_irq_idle", 32'(busy), 32'd0);
    irq = 1'b0;

    pstat = 8'h00; brk = 1'b1;
    push_seq(2'd3, 2'd1, 8'hF0, 16'h8000, 8'h00, 7);
    run_seq(0, 3, 16'h0, lat);
    check("hijack_pcnew", 32'(pcnew), 32'h9ABC);
    repeat (8) @(posedge clk);
    #1;
    check("held_nmi_idle", 32'(busy), 32'd0);
    nmi = 1'b0;

    sp = 8'hFD; pc = 16'hC005; iflag = 1'b0; irq = 1'b1;
    push_seq(2'd2, 2'd2, 8'hFD, 16'hC005, 8'h00, 7);
    run_seq(5, 0, 16'hFFFE, lat);
    iflag = 1'b1;
    check("stall_latency", 32'(lat), 32'd10);

    iflag = 1'b0; irq = 1'b1;
    push_seq(2'd2, 2'd2, 8'hFD, 16'hC005, 8'h00, 3);
    @(posedge clk); #1;
    irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_pushp", 32'(spdec), 32'd1);
    clr = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_rw", 32'(rw), 32'd0);
    iflag = 1'b1;
    push_seq(2'd0, 2'd0, 8'hFD, 16'hC005, 8'h00, 7);
    @(posedge clk); #1;
    clr = 1'b0;
    run_seq(0, 0, 16'h0, lat);
    check("abort_reset_latency", 32'(lat), 32'd7);
    check("abort_reset_pcnew", 32'(pcnew), 32'h1234);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
